// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    // How a finished product is folded into {hi,lo}.
    typedef enum logic [1:0] {
        MC_SET = 2'd0,
        MC_ADD = 2'd1,
        MC_SUB = 2'd2
    } mul_commit_e;

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_if
// Description : E-stage request / HI-LO result bundle of the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iter_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    md_op_e           md_op;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, abort, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, abort, a, b,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : One combinational restoring shift-subtract division step.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_dividend_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_q_bit
);
    logic [WIDTH:0] w_shifted;

    assign w_shifted = {i_rem, i_dividend_bit};
    assign o_q_bit   = (w_shifted >= {1'b0, i_divisor});
    // When the subtract succeeds the result is below the divisor, so WIDTH bits hold it.
    assign o_rem     = o_q_bit ? (w_shifted[WIDTH-1:0] - i_divisor) : w_shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : HI/LO registers with multi-cycle mult/madd/msub and a
//               radix-2 restoring divider for the E stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_iter_if.slave  mdu
);
    localparam int c_DIV_CYCLES = WIDTH;
    localparam int c_MAX_CNT    = (MULT_CYCLES > c_DIV_CYCLES) ? MULT_CYCLES : c_DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(c_DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    mdu_state_e         r_state,    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [WIDTH-1:0]   r_hi,       w_hi_nxt;
    logic [WIDTH-1:0]   r_lo,       w_lo_nxt;
    logic [2*WIDTH-1:0] r_prod,     w_prod_nxt;
    mul_commit_e        r_mul_op,   w_mul_op_nxt;
    logic [WIDTH-1:0]   r_quot,     w_quot_nxt;
    logic [WIDTH-1:0]   r_rem,      w_rem_nxt;
    logic [WIDTH-1:0]   r_divisor,  w_divisor_nxt;
    logic               r_neg_q,    w_neg_q_nxt;
    logic               r_neg_r,    w_neg_r_nxt;
    logic               r_div_zero, w_div_zero_nxt;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_q;
    logic [WIDTH-1:0]   w_quot_final;

    assign w_signed  = op_is_signed(mdu.md_op);
    // Extending to 2*WIDTH makes the low half of one product correct for both signednesses.
    assign w_ext_a   = w_signed ? {{WIDTH{mdu.a[WIDTH-1]}}, mdu.a} : {{WIDTH{1'b0}}, mdu.a};
    assign w_ext_b   = w_signed ? {{WIDTH{mdu.b[WIDTH-1]}}, mdu.b} : {{WIDTH{1'b0}}, mdu.b};
    assign w_product = w_ext_a * w_ext_b;
    assign w_abs_a   = (w_signed && mdu.a[WIDTH-1]) ? (~mdu.a + 1'b1) : mdu.a;
    assign w_abs_b   = (w_signed && mdu.b[WIDTH-1]) ? (~mdu.b + 1'b1) : mdu.b;

    // r_quot shifts dividend bits out of the top while quotient bits enter at the bottom.
    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem          (r_rem),
        .i_dividend_bit (r_quot[WIDTH-1]),
        .i_divisor      (r_divisor),
        .o_rem          (w_step_rem),
        .o_q_bit        (w_step_q)
    );

    assign w_quot_final = {r_quot[WIDTH-2:0], w_step_q};

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_prod_nxt     = r_prod;
        w_mul_op_nxt   = r_mul_op;
        w_quot_nxt     = r_quot;
        w_rem_nxt      = r_rem;
        w_divisor_nxt  = r_divisor;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_div_zero_nxt = r_div_zero;

        case (r_state)
            IDLE: begin
                if (mdu.start && !mdu.abort) begin
                    case (mdu.md_op)
                        MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                            w_prod_nxt  = w_product;
                            w_cnt_nxt   = c_MULT_CNT;
                            w_state_nxt = MUL;
                            if (mdu.md_op == MD_MADD || mdu.md_op == MD_MADDU)
                                w_mul_op_nxt = MC_ADD;
                            else if (mdu.md_op == MD_MSUB || mdu.md_op == MD_MSUBU)
                                w_mul_op_nxt = MC_SUB;
                            else
                                w_mul_op_nxt = MC_SET;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_quot_nxt     = w_abs_a;
                            w_divisor_nxt  = w_abs_b;
                            w_rem_nxt      = '0;
                            w_neg_q_nxt    = w_signed && (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
                            w_neg_r_nxt    = w_signed && mdu.a[WIDTH-1];
                            w_div_zero_nxt = (mdu.b == '0);
                            w_cnt_nxt      = c_DIV_CNT;
                            w_state_nxt    = DIV;
                        end
                        MD_MTHI: w_hi_nxt = mdu.a;
                        MD_MTLO: w_lo_nxt = mdu.a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = IDLE;
                    case (r_mul_op)
                        MC_ADD:  {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} + r_prod;
                        MC_SUB:  {w_hi_nxt, w_lo_nxt} = {r_hi, r_lo} - r_prod;
                        default: {w_hi_nxt, w_lo_nxt} = r_prod;
                    endcase
                end
            end
            DIV: begin
                w_cnt_nxt  = r_cnt - c_CNT_ONE;
                w_rem_nxt  = w_step_rem;
                w_quot_nxt = w_quot_final;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_nxt = IDLE;
                    // Divide by zero burns the full latency but leaves HI/LO untouched.
                    if (!r_div_zero) begin
                        w_lo_nxt = r_neg_q ? (~w_quot_final + 1'b1) : w_quot_final;
                        w_hi_nxt = r_neg_r ? (~w_step_rem + 1'b1) : w_step_rem;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_prod     <= '0;
            r_mul_op   <= MC_SET;
            r_quot     <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_prod     <= w_prod_nxt;
            r_mul_op   <= w_mul_op_nxt;
            r_quot     <= w_quot_nxt;
            r_rem      <= w_rem_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign mdu.busy = (r_state != IDLE);
    assign mdu.hi   = r_hi;
    assign mdu.lo   = r_lo;

endmodule
`default_nettype wire
